spi_slave_regfile: RTL and testbench

- Parametrised SPI slave with an internal register file. Data width, register count and SPI mode (CPOL/CPHA) are configurable.
- A single SS frame carries one command word followed by a burst of data words. The register address auto-increments after every data word.
- Sits between the board SPI pins and local consumers (FND display path, control logic). Register contents are exported as a flat bus.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_edge_sync.sv | 47 ++++
 rtl/spi_slave_regfile.sv | 144 ++++++++++++++
 tb/tb_spi_slave_regfile.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, mode encodings and command-word field helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } spi_state_e;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Write/read flag position inside a command word of the given width
  function automatic int unsigned cmd_wr_bit(input int unsigned data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronisers for SCLK/MOSI/SS plus mode-aware edge detection.
module spi_edge_sync #(
  parameter int unsigned CPOL = 0,
  parameter int unsigned CPHA = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic mosi,
  input  logic ss,
  output logic sample_edge,
  output logic shift_edge,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  // [0] metastable stage, [1] synchronised, [2] previous synchronised value
  logic [2:0] sclk_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;
  logic       lead_c;
  logic       trail_c;

  // SS chain resets low so a master still holding SS low after reset never looks like a fresh fall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q <= {3{1'(CPOL)}};
      ss_q   <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      ss_q   <= {ss_q[1:0], ss};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign lead_c  = (sclk_q[2] == 1'(CPOL)) && (sclk_q[1] != 1'(CPOL));
  assign trail_c = (sclk_q[2] != 1'(CPOL)) && (sclk_q[1] == 1'(CPOL));

  assign sample_edge = (CPHA == 0) ? lead_c  : trail_c;
  assign shift_edge  = (CPHA == 0) ? trail_c : lead_c;
  assign ss_fall     = ss_q[2] && !ss_q[1];
  assign ss_rise     = !ss_q[2] && ss_q[1];
  assign mosi_s      = mosi_q[1];

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave with a burst-addressed register file: one command word then
// auto-incrementing write or read data words per SS frame.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned CPOL     = 0,
  parameter int unsigned CPHA     = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       SCLK,
  input  logic                       MOSI,
  input  logic                       SS,
  output logic                       MISO,
  output logic                       miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       busy
);

  localparam int unsigned CNT_W      = $clog2(DATA_W);
  localparam int unsigned CMD_WR_BIT = cmd_wr_bit(DATA_W);

  logic sample_edge;
  logic shift_edge;
  logic ss_fall;
  logic ss_rise;
  logic mosi_s;

  spi_edge_sync #(
    .CPOL(CPOL),
    .CPHA(CPHA)
  ) u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .sclk       (SCLK),
    .mosi       (MOSI),
    .ss         (SS),
    .sample_edge(sample_edge),
    .shift_edge (shift_edge),
    .ss_fall    (ss_fall),
    .ss_rise    (ss_rise),
    .mosi_s     (mosi_s)
  );

  spi_state_e                       state;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic [DATA_W-2:0]                rx_sh;
  logic [DATA_W-1:0]                tx_reg;
  logic [CNT_W-1:0]                 bit_cnt;
  logic [ADDR_W-1:0]                addr;
  logic                             skip_shift;
  logic [DATA_W-1:0]                word_c;
  logic                             word_done_c;

  assign word_c      = {rx_sh, mosi_s};
  assign word_done_c = sample_edge && (bit_cnt == CNT_W'(DATA_W - 1));

  // tx_reg is held at zero outside RDATA, so MISO needs no extra gating
  assign MISO      = tx_reg[DATA_W-1];
  assign regs_flat = regs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      regs       <= '0;
      rx_sh      <= '0;
      tx_reg     <= '0;
      bit_cnt    <= '0;
      addr       <= '0;
      skip_shift <= 1'b0;
      miso_oe    <= 1'b0;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
      busy       <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      if (ss_rise) begin
        // End of frame: any partial word is simply dropped
        state      <= IDLE;
        busy       <= 1'b0;
        miso_oe    <= 1'b0;
        tx_reg     <= '0;
        skip_shift <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              state      <= CMD;
              busy       <= 1'b1;
              bit_cnt    <= '0;
              tx_reg     <= '0;
              skip_shift <= 1'b1;
            end
          end
          default: begin
            if (sample_edge) begin
              rx_sh   <= word_c[DATA_W-2:0];
              bit_cnt <= word_done_c ? '0 : bit_cnt + CNT_W'(1);
            end
            // First shift edge after a load is swallowed so the MSB lasts a full bit
            if (shift_edge) begin
              if (skip_shift) skip_shift <= 1'b0;
              else            tx_reg     <= {tx_reg[DATA_W-2:0], 1'b0};
            end
            if (word_done_c) begin
              case (state)
                CMD: begin
                  if (word_c[CMD_WR_BIT]) begin
                    state <= WDATA;
                    addr  <= word_c[ADDR_W-1:0];
                  end else begin
                    state      <= RDATA;
                    miso_oe    <= 1'b1;
                    tx_reg     <= regs[word_c[ADDR_W-1:0]];
                    addr       <= word_c[ADDR_W-1:0] + ADDR_W'(1);
                    skip_shift <= 1'b1;
                  end
                end
                WDATA: begin
                  regs[addr] <= word_c;
                  wr_pulse   <= 1'b1;
                  wr_addr    <= addr;
                  addr       <= addr + ADDR_W'(1);
                end
                RDATA: begin
                  tx_reg     <= regs[addr];
                  addr       <= addr + ADDR_W'(1);
                  skip_shift <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench: one DUT per SPI mode driven by a bit-level master model.
module tb_spi_slave_regfile;

  logic       clk;
  logic       reset;
  logic       mosi;
  logic [3:0] sclk;
  logic [3:0] ss;
  logic [3:0] miso;
  logic [3:0] oe;
  logic [3:0] wrp;
  logic [3:0] busy;
  logic [31:0] rf [4];
  logic [1:0]  wa [4];

  int n_tot  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_regfile #(
      .DATA_W  (8),
      .NUM_REGS(4),
      .CPOL    (g / 2),
      .CPHA    (g % 2)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .SCLK     (sclk[g]),
      .MOSI     (mosi),
      .SS       (ss[g]),
      .MISO     (miso[g]),
      .miso_oe  (oe[g]),
      .regs_flat(rf[g]),
      .wr_pulse (wrp[g]),
      .wr_addr  (wa[g]),
      .busy     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write-pulse log per instance, sampled away from the active edge
  int         pcnt [4];
  logic [1:0] wlog [4][8];
  initial for (int i = 0; i < 4; i++) pcnt[i] = 0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wrp[i] === 1'b1) begin
        wlog[i][pcnt[i] % 8] = wa[i];
        pcnt[i] = pcnt[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  // Master model: MSB first, samples MISO on the mode-correct edge
  task automatic spi_bits(input int m, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic oe_any, output logic oe_all);
    logic cpol;
    logic cpha;
    cpol   = 1'(m / 2);
    cpha   = 1'(m % 2);
    rx     = 8'h00;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) begin
        mosi = tx[i];
        half();
        sclk[m] = ~cpol;
        rx[i] = miso[m];
        oe_any |= oe[m];
        oe_all &= oe[m];
        half();
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi = tx[i];
        half();
        sclk[m] = cpol;
        rx[i] = miso[m];
        oe_any |= oe[m];
        oe_all &= oe[m];
        half();
      end
    end
  endtask

  logic [7:0] txw [8];
  logic [7:0] rxw [8];
  logic       oeok [8];

  task automatic run_frame(input int m, input int n);
    logic [7:0] r;
    logic oa;
    logic ol;
    logic rd;
    rd = !txw[0][7];
    ss[m] = 1'b0;
    half();
    for (int j = 0; j < n; j++) begin
      spi_bits(m, txw[j], 8, r, oa, ol);
      rxw[j]  = r;
      oeok[j] = (rd && j > 0) ? ol : !oa;
    end
    half();
    ss[m] = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  typedef struct packed {
    int             m;
    int             n;
    logic [3:0][7:0] w;
    logic [3:0][7:0] rx;
    logic [31:0]    regs;
    int             pulses;
    logic [1:0]     fa;
    logic [1:0]     la;
  } vec_t;

  function automatic vec_t mkv(input int m, input int n,
                               input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2, input logic [7:0] w3,
                               input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3,
                               input logic [31:0] regs, input int pulses,
                               input logic [1:0] fa, input logic [1:0] la);
    vec_t v;
    v.m = m; v.n = n;
    v.w = {w3, w2, w1, w0};
    v.rx = {r3, r2, r1, 8'h00};
    v.regs = regs; v.pulses = pulses; v.fa = fa; v.la = la;
    return v;
  endfunction

  vec_t vecs [10];

  initial begin
    logic [7:0] r;
    logic oa;
    logic ol;
    int   p0;

    vecs[0] = mkv(0, 3, 8'h81, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00A53C00, 2, 2'd1, 2'd2);
    vecs[1] = mkv(0, 4, 8'h01, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hA5, 8'h00, 32'h00A53C00, 0, 2'd0, 2'd0);
    vecs[2] = mkv(0, 3, 8'h83, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 32'h11A53C22, 2, 2'd3, 2'd0);
    vecs[3] = mkv(0, 3, 8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00, 32'h11A53C22, 0, 2'd0, 2'd0);
    vecs[4] = mkv(1, 2, 8'h80, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0000005A, 1, 2'd0, 2'd0);
    vecs[5] = mkv(1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 32'h0000005A, 0, 2'd0, 2'd0);
    vecs[6] = mkv(2, 2, 8'h80, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0000005A, 1, 2'd0, 2'd0);
    vecs[7] = mkv(2, 2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 32'h0000005A, 0, 2'd0, 2'd0);
    vecs[8] = mkv(3, 2, 8'h80, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0000005A, 1, 2'd0, 2'd0);
    vecs[9] = mkv(3, 2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 32'h0000005A, 0, 2'd0, 2'd0);

    reset = 1'b0;
    mosi  = 1'b0;
    sclk  = 4'b1100;
    ss    = 4'hF;
    repeat (5) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("reset_regs_m%0d", m), rf[m], 32'h0);
      chk($sformatf("reset_busy_m%0d", m), 32'(busy[m]), 32'h0);
      chk($sformatf("reset_oe_m%0d", m), 32'(oe[m]), 32'h0);
      chk($sformatf("reset_miso_m%0d", m), 32'(miso[m]), 32'h0);
      chk($sformatf("reset_wraddr_m%0d", m), 32'(wa[m]), 32'h0);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      p0 = pcnt[vecs[v].m];
      for (int j = 0; j < 4; j++) txw[j] = vecs[v].w[j];
      run_frame(vecs[v].m, vecs[v].n);
      for (int j = 0; j < vecs[v].n; j++) begin
        chk($sformatf("v%0d_rx%0d", v, j), 32'(rxw[j]), 32'(vecs[v].rx[j]));
        chk($sformatf("v%0d_oe%0d", v, j), 32'(oeok[j]), 32'h1);
      end
      chk($sformatf("v%0d_regs", v), rf[vecs[v].m], vecs[v].regs);
      chk($sformatf("v%0d_pulses", v), 32'(pcnt[vecs[v].m] - p0), 32'(vecs[v].pulses));
      if (vecs[v].pulses > 0) begin
        chk($sformatf("v%0d_first_wraddr", v), 32'(wlog[vecs[v].m][p0 % 8]), 32'(vecs[v].fa));
        chk($sformatf("v%0d_last_wraddr", v),
            32'(wlog[vecs[v].m][(pcnt[vecs[v].m] - 1) % 8]), 32'(vecs[v].la));
      end
    end

    // Abort: SS rises five bits into a data word
    p0 = pcnt[0];
    ss[0] = 1'b0;
    half();
    spi_bits(0, 8'h80, 8, r, oa, ol);
    spi_bits(0, 8'hFF, 5, r, oa, ol);
    chk("abort_busy_mid", 32'(busy[0]), 32'h1);
    half();
    ss[0] = 1'b1;
    repeat (16) @(negedge clk);
    chk("abort_no_pulse", 32'(pcnt[0] - p0), 32'h0);
    chk("abort_regs", rf[0], 32'h11A53C22);
    chk("abort_busy_after", 32'(busy[0]), 32'h0);
    txw[0] = 8'h80; txw[1] = 8'h77;
    run_frame(0, 2);
    chk("after_abort_regs", rf[0], 32'h11A53C77);
    chk("after_abort_pulse", 32'(pcnt[0] - p0), 32'h1);
    chk("after_abort_wraddr", 32'(wa[0]), 32'h0);

    // Reset in the middle of a read burst
    ss[0] = 1'b0;
    half();
    spi_bits(0, 8'h01, 8, r, oa, ol);
    spi_bits(0, 8'h00, 3, r, oa, ol);
    chk("rst_pre_oe", 32'(oe[0]), 32'h1);
    chk("rst_pre_busy", 32'(busy[0]), 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_miso", 32'(miso[0]), 32'h0);
    chk("rst_oe", 32'(oe[0]), 32'h0);
    chk("rst_regs", rf[0], 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    p0 = pcnt[0];
    spi_bits(0, 8'hFF, 5, r, oa, ol);
    chk("rst_held_ss_busy", 32'(busy[0]), 32'h0);
    chk("rst_held_ss_oe", 32'(oa), 32'h0);
    half();
    ss[0] = 1'b1;
    repeat (16) @(negedge clk);
    chk("rst_held_ss_nowrite", 32'(pcnt[0] - p0), 32'h0);
    txw[0] = 8'h81; txw[1] = 8'h42;
    run_frame(0, 2);
    chk("post_rst_regs", rf[0], 32'h00004200);
    txw[0] = 8'h01; txw[1] = 8'h00;
    run_frame(0, 2);
    chk("post_rst_read", 32'(rxw[1]), 32'h42);
    chk("post_rst_oe", 32'(oeok[1]), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
